// File: rtl/multi_counter.sv
// multi_counter: NCH independent up/down counter/timer channels behind a simple
// valid/ready register port, with a channel-0 logic-analyzer preload path.
module multi_counter #(
  parameter int BITS = 32,
  parameter int NCH  = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                valid,
  input  logic [3:0]          wstrb,
  input  logic [31:0]         addr,
  input  logic [31:0]         wdata,
  output logic                ready,
  output logic [31:0]         rdata,
  input  logic [BITS-1:0]     la_write,
  input  logic [BITS-1:0]     la_input,
  output logic [NCH*BITS-1:0] count,
  output logic [NCH-1:0]      irq
);

  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {
    REG_CTRL   = 2'd0,
    REG_COUNT  = 2'd1,
    REG_LIMIT  = 2'd2,
    REG_STATUS = 2'd3
  } reg_e;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  be);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[b*8 +: 8] = be[b] ? new_val[b*8 +: 8] : old_val[b*8 +: 8];
    end
    return res;
  endfunction

  logic [BITS-1:0] count_q [NCH];
  logic [BITS-1:0] limit_q [NCH];
  logic [NCH-1:0]  en_q, dir_q, reload_q, irq_en_q, hit_q;

  logic            accept, ch_valid, wr_en;
  logic [CH_W-1:0] ch_idx;
  reg_e            reg_sel;
  logic            unused_addr_bits;

  assign accept   = valid && !ready;
  // The whole upper address is decoded so an index of NCH is out of range
  // even when NCH is a power of two.
  assign ch_valid = (addr[31:4] < 28'(NCH));
  assign ch_idx   = addr[4+CH_W-1:4];
  assign reg_sel  = reg_e'(addr[3:2]);
  assign wr_en    = accept && ch_valid && (wstrb != 4'b0000);
  assign unused_addr_bits = ^addr[1:0];

  logic [NCH-1:0]  sel, fire, terminal;
  logic [BITS-1:0] step_val  [NCH];
  logic [BITS-1:0] count_wr  [NCH];
  logic [BITS-1:0] limit_wr  [NCH];
  logic [31:0]     rd_val;

  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    sel      = '0;
    fire     = '0;
    terminal = '0;
    rd_val   = '0;
    for (int i = 0; i < NCH; i++) begin
      step_val[i] = count_q[i];
      count_wr[i] = BITS'(merge_bytes(32'(count_q[i]), wdata, wstrb));
      limit_wr[i] = BITS'(merge_bytes(32'(limit_q[i]), wdata, wstrb));
      terminal[i] = dir_q[i] ? (count_q[i] == '0) : (count_q[i] == limit_q[i]);
      fire[i]     = en_q[i] && terminal[i];
      sel[i]      = wr_en && (ch_idx == CH_W'(i));
      if (!terminal[i]) begin
        step_val[i] = dir_q[i] ? count_q[i] - 1'b1 : count_q[i] + 1'b1;
      end else if (reload_q[i]) begin
        step_val[i] = dir_q[i] ? limit_q[i] : '0;
      end
      if (ch_valid && (ch_idx == CH_W'(i))) begin
        case (reg_sel)
          REG_CTRL:   rd_val = {28'b0, irq_en_q[i], reload_q[i], dir_q[i], en_q[i]};
          REG_COUNT:  rd_val = 32'(count_q[i]);
          REG_LIMIT:  rd_val = 32'(limit_q[i]);
          REG_STATUS: rd_val = {31'b0, hit_q[i]};
          default:    rd_val = '0;
        endcase
      end
    end
  end

  // NOTE: count/limit arrays are reset like plain flops because their reset
  // values are architecturally visible on the count bus and through reads.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ready    <= 1'b0;
      rdata    <= '0;
      en_q     <= '0;
      dir_q    <= '0;
      reload_q <= '0;
      irq_en_q <= '0;
      hit_q    <= '0;
      for (int i = 0; i < NCH; i++) begin
        count_q[i] <= '0;
        limit_q[i] <= '1;
      end
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values,
      // e.g. rdata captures the register contents before this cycle's write.
      ready <= accept;
      if (accept) rdata <= rd_val;
      for (int i = 0; i < NCH; i++) begin
        if (sel[i] && reg_sel == REG_COUNT) begin
          count_q[i] <= count_wr[i];
        end else if (i == 0 && la_write != '0) begin
          count_q[i] <= la_write & la_input;
        end else if (en_q[i]) begin
          count_q[i] <= step_val[i];
        end

        if (sel[i] && reg_sel == REG_LIMIT) limit_q[i] <= limit_wr[i];

        if (sel[i] && reg_sel == REG_CTRL && wstrb[0]) begin
          en_q[i]     <= wdata[0];
          dir_q[i]    <= wdata[1];
          reload_q[i] <= wdata[2];
          irq_en_q[i] <= wdata[3];
        end else if (fire[i] && !reload_q[i]) begin
          en_q[i] <= 1'b0;
        end

        // A terminal event beats a simultaneous write-one-to-clear.
        if (fire[i]) begin
          hit_q[i] <= 1'b1;
        end else if (sel[i] && reg_sel == REG_STATUS && wstrb[0] && wdata[0]) begin
          hit_q[i] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    count = '0;
    for (int i = 0; i < NCH; i++) count[i*BITS +: BITS] = count_q[i];
  end

  assign irq = hit_q & irq_en_q;

endmodule
